// File: rtl/pfd_multichan_pkg.sv
// Shared types and helpers for the multi-channel phase-frequency detector.
// Optional lock detector is enabled with PFD_LOCK_DETECT_EN.
package pfd_multichan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UP_WAIT = 2'd1,
    DN_WAIT = 2'd2,
    HOLD    = 2'd3
  } pfd_state_e;

  // Bits needed to hold a counter that reaches max_val inclusive.
  function automatic int pfd_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // |err| <= tol, with the most negative value saturated rather than wrapped.
  function automatic logic pfd_in_tol(input logic signed [31:0] err, input int unsigned tol);
    logic [31:0] mag;
    if (err == 32'sh8000_0000) mag = 32'h7fff_ffff;
    else if (err < 0)          mag = $unsigned(-err);
    else                       mag = $unsigned(err);
    return (mag <= tol);
  endfunction

endpackage

// File: rtl/pfd_multichan_if.sv
// Detector bus: per-channel ref/data inputs and pump/error outputs.
interface pfd_multichan_if #(
  parameter int N_CH  = 1,
  parameter int ERR_W = 8
) ();
  logic [N_CH-1:0]       ref_in;
  logic [N_CH-1:0]       data_in;
  logic [N_CH-1:0]       up;
  logic [N_CH-1:0]       down;
  logic [N_CH*ERR_W-1:0] phase_err;
  logic [N_CH-1:0]       err_valid;
  logic [N_CH-1:0]       lock;

  modport master (output ref_in, data_in, input up, down, phase_err, err_valid, lock);
  modport slave  (input ref_in, data_in, output up, down, phase_err, err_valid, lock);
endinterface

// File: rtl/pfd_multichan_chan.sv
// One detector channel: synchroniser, edge detect, UP/DOWN FSM, optional lock
// detector (PFD_LOCK_DETECT_EN).
module pfd_multichan_chan
  import pfd_multichan_pkg::*;
#(
  parameter int ERR_W    = 8,
  parameter int DZ_CYC   = 2,
  parameter int MAX_WAIT = 100,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_ref,
  input  logic                    i_dat,
  output logic                    o_up,
  output logic                    o_down,
  output logic signed [ERR_W-1:0] o_err,
  output logic                    o_err_vld,
  output logic                    o_lock
);
  localparam int CW = pfd_cnt_w(MAX_WAIT);
  localparam int HW = pfd_cnt_w(DZ_CYC);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
  localparam logic [HW-1:0] HOLD_MAX = HW'(DZ_CYC);

  logic [2:0] r_ref_sync, r_dat_sync;
  pfd_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hcnt;
  logic r_pend_ref, r_pend_dat, r_up, r_down, r_err_vld;
  logic signed [ERR_W-1:0] r_err;

  logic w_ref_edge, w_dat_edge, w_hold_exit, w_ref_any, w_dat_any;
  logic w_ev, w_ev_tmo;
  logic signed [ERR_W-1:0] w_ev_err, w_cnt_s;

  // Two sync flops plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_sync <= '0;
      r_dat_sync <= '0;
    end else begin
      r_ref_sync <= {r_ref_sync[1:0], i_ref};
      r_dat_sync <= {r_dat_sync[1:0], i_dat};
    end
  end

  assign w_ref_edge  = r_ref_sync[1] & ~r_ref_sync[2];
  assign w_dat_edge  = r_dat_sync[1] & ~r_dat_sync[2];
  assign w_hold_exit = (r_state == HOLD) && (r_hcnt == HOLD_MAX);
  // On HOLD exit, captured edges count as if they arrived in IDLE this cycle.
  assign w_ref_any   = w_ref_edge | (w_hold_exit & r_pend_ref);
  assign w_dat_any   = w_dat_edge | (w_hold_exit & r_pend_dat);
  assign w_cnt_s     = ERR_W'(r_cnt);

  always_comb begin
    w_ev     = 1'b0;
    w_ev_tmo = 1'b0;
    w_ev_err = '0;
    case (r_state)
      IDLE, HOLD: begin
        if ((r_state == IDLE || w_hold_exit) && w_ref_any && w_dat_any) w_ev = 1'b1;
      end
      UP_WAIT: begin
        if (w_dat_edge || r_cnt == CNT_MAX) begin
          w_ev     = 1'b1;
          w_ev_tmo = ~w_dat_edge;
          w_ev_err = w_cnt_s;
        end
      end
      DN_WAIT: begin
        if (w_ref_edge || r_cnt == CNT_MAX) begin
          w_ev     = 1'b1;
          w_ev_tmo = ~w_ref_edge;
          w_ev_err = -w_cnt_s;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hcnt     <= '0;
      r_pend_ref <= 1'b0;
      r_pend_dat <= 1'b0;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_err      <= '0;
      r_err_vld  <= 1'b0;
    end else begin
      r_err_vld <= w_ev;
      if (w_ev) r_err <= w_ev_err;
      case (r_state)
        IDLE, HOLD: begin
          if (r_state == HOLD && !w_hold_exit) begin
            r_hcnt     <= r_hcnt + HW'(1);
            r_pend_ref <= r_pend_ref | w_ref_edge;
            r_pend_dat <= r_pend_dat | w_dat_edge;
          end else begin
            r_pend_ref <= 1'b0;
            r_pend_dat <= 1'b0;
            if (w_ref_any && w_dat_any) begin
              r_state <= HOLD;
              r_up    <= 1'b1;
              r_down  <= 1'b1;
              r_hcnt  <= HW'(1);
            end else if (w_ref_any) begin
              r_state <= UP_WAIT;
              r_up    <= 1'b1;
              r_down  <= 1'b0;
              r_cnt   <= CW'(1);
            end else if (w_dat_any) begin
              r_state <= DN_WAIT;
              r_up    <= 1'b0;
              r_down  <= 1'b1;
              r_cnt   <= CW'(1);
            end else begin
              r_state <= IDLE;
              r_up    <= 1'b0;
              r_down  <= 1'b0;
            end
          end
        end
        UP_WAIT: begin
          // Extra ref edges here are dropped: that is what gives frequency detection.
          if (w_dat_edge || r_cnt == CNT_MAX) begin
            r_state <= HOLD;
            r_down  <= 1'b1;
            r_hcnt  <= HW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DN_WAIT: begin
          if (w_ref_edge || r_cnt == CNT_MAX) begin
            r_state <= HOLD;
            r_up    <= 1'b1;
            r_hcnt  <= HW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_up      = r_up;
  assign o_down    = r_down;
  assign o_err     = r_err;
  assign o_err_vld = r_err_vld;

`ifdef PFD_LOCK_DETECT_EN
  localparam int RW = pfd_cnt_w(LOCK_CNT);
  localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_CNT);

  logic [RW-1:0] r_run;
  logic          r_lock;

  // Lock tracks the event being reported, so it moves on the err_valid edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= '0;
      r_lock <= 1'b0;
    end else if (w_ev) begin
      if (!w_ev_tmo && pfd_in_tol(32'(w_ev_err), LOCK_TOL)) begin
        if (r_run != RUN_MAX) r_run <= r_run + RW'(1);
        r_lock <= (r_run >= RUN_MAX - RW'(1));
      end else begin
        r_run  <= '0;
        r_lock <= 1'b0;
      end
    end
  end

  assign o_lock = r_lock;
`else
  logic w_lock_unused;
  assign w_lock_unused = (LOCK_TOL != 0) ^ (LOCK_CNT != 0) ^ w_ev_tmo;
  assign o_lock        = 1'b0;
`endif

endmodule

// File: rtl/pfd_multichan.sv
// N-channel clocked phase-frequency detector; channels are independent.
// Lock detection is built only when PFD_LOCK_DETECT_EN is defined.
module pfd_multichan
  import pfd_multichan_pkg::*;
#(
  parameter int N_CH     = 1,
  parameter int ERR_W    = 8,
  parameter int DZ_CYC   = 2,
  parameter int MAX_WAIT = 100,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic           clk,
  input  logic           temp_reset_out,
  pfd_multichan_if.slave bus
);
  logic [N_CH-1:0]            w_up, w_down, w_vld, w_lock;
  logic [N_CH-1:0][ERR_W-1:0] w_err;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pfd_multichan_chan #(
      .ERR_W(ERR_W), .DZ_CYC(DZ_CYC), .MAX_WAIT(MAX_WAIT),
      .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)
    ) u_chan (
      .clk      (clk),
      .rst_n    (temp_reset_out),
      .i_ref    (bus.ref_in[g]),
      .i_dat    (bus.data_in[g]),
      .o_up     (w_up[g]),
      .o_down   (w_down[g]),
      .o_err    (w_err[g]),
      .o_err_vld(w_vld[g]),
      .o_lock   (w_lock[g])
    );
  end

  assign bus.up        = w_up;
  assign bus.down      = w_down;
  assign bus.phase_err = w_err;
  assign bus.err_valid = w_vld;
  assign bus.lock      = w_lock;

endmodule

// File: tb/tb_pfd_multichan.sv
// Bench for pfd_multichan: vector table plus hand sequences, scoreboard of
// expected phase errors checked on every err_valid strobe.
module tb_pfd_multichan;
  localparam int N_CH = 2, ERR_W = 8, DZ = 2, MAX_WAIT = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pfd_multichan_if #(.N_CH(N_CH), .ERR_W(ERR_W)) bus ();

  pfd_multichan #(
    .N_CH(N_CH), .ERR_W(ERR_W), .DZ_CYC(DZ), .MAX_WAIT(MAX_WAIT),
    .LOCK_TOL(2), .LOCK_CNT(16)
  ) dut (
    .clk           (clk),
    .temp_reset_out(rst_n),
    .bus           (bus)
  );

  typedef struct {
    int ch;
    bit ur;
    int ra;
    bit ud;
    int da;
    int exp;
  } vec_t;

  int nvec = 0, nerr = 0;
  int q0[$], q1[$];
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int err_of(input int c);
    return int'($signed(bus.phase_err[c*ERR_W +: ERR_W]));
  endfunction

  function automatic int qsize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int c, input int e);
    if (c == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (bus.err_valid[c] === 1'b1) begin
        if (qsize(c) == 0)
          chk($sformatf("spurious err_valid ch%0d", c), int'(bus.err_valid[c]), 0);
        else if (c == 0)
          chk("phase_err ch0", err_of(0), q0.pop_front());
        else
          chk("phase_err ch1", err_of(1), q1.pop_front());
      end
    end
  end

  task automatic drain(input int c);
    int to;
    to = 0;
    while (qsize(c) != 0 && to < 300) begin
      @(negedge clk);
      to++;
    end
    if (qsize(c) != 0) begin
      chk($sformatf("err_valid never came ch%0d", c), qsize(c), 0);
      if (c == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic settle(input int c);
    @(negedge clk);
    bus.ref_in[c]  = 1'b0;
    bus.data_in[c] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    int last;
    last = (v.ra > v.da) ? v.ra : v.da;
    push(v.ch, v.exp);
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      if (v.ur && t == v.ra) bus.ref_in[v.ch]  = 1'b1;
      if (v.ud && t == v.da) bus.data_in[v.ch] = 1'b1;
    end
    drain(v.ch);
    settle(v.ch);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 1'b1, 0, 1'b1, 5,   5};
    tbl[1]  = '{0, 1'b1, 3, 1'b1, 0,   -3};
    tbl[2]  = '{0, 1'b1, 0, 1'b1, 0,   0};
    tbl[3]  = '{0, 1'b1, 0, 1'b1, 1,   1};
    tbl[4]  = '{0, 1'b1, 7, 1'b1, 0,   -7};
    tbl[5]  = '{0, 1'b1, 0, 1'b0, 0,   100};
    tbl[6]  = '{0, 1'b0, 0, 1'b1, 0,   -100};
    tbl[7]  = '{0, 1'b1, 0, 1'b1, 100, 100};
    tbl[8]  = '{0, 1'b1, 0, 1'b1, 99,  99};
    tbl[9]  = '{1, 1'b1, 0, 1'b1, 2,   2};
    tbl[10] = '{1, 1'b1, 4, 1'b1, 4,   0};

    bus.ref_in  = '0;
    bus.data_in = '0;

    // Reset held while inputs toggle.
    repeat (6) begin
      @(negedge clk);
      bus.ref_in  = N_CH'($urandom);
      bus.data_in = N_CH'($urandom);
    end
    chk("rst up", int'(bus.up), 0);
    chk("rst down", int'(bus.down), 0);
    chk("rst err_valid", int'(bus.err_valid), 0);
    chk("rst phase_err", int'(bus.phase_err), 0);
    chk("rst lock", int'(bus.lock), 0);
    bus.ref_in  = '0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst up", int'(bus.up), 0);
    chk("post-rst down", int'(bus.down), 0);
    chk("post-rst err_valid", int'(bus.err_valid), 0);

    // ref leads data by 5: up from +3, HOLD at +8/+9, clear at +10.
    @(negedge clk);
    bus.ref_in[0] = 1'b1;
    push(0, 5);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("seq5 up k=%0d", k), int'(bus.up[0]), int'(k >= 3 && k <= 9));
      chk($sformatf("seq5 down k=%0d", k), int'(bus.down[0]), int'(k == 8 || k == 9));
      if (k == 5) bus.data_in[0] = 1'b1;
    end
    drain(0);
    settle(0);

    // Same-cycle edges: both pulses exactly DZ cycles.
    @(negedge clk);
    bus.ref_in[0]  = 1'b1;
    bus.data_in[0] = 1'b1;
    push(0, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("same up k=%0d", k), int'(bus.up[0]), int'(k == 3 || k == 4));
      chk($sformatf("same down k=%0d", k), int'(bus.down[0]), int'(k == 3 || k == 4));
    end
    drain(0);
    settle(0);

    // ref re-rises during HOLD: captured, UP_WAIT resumes on exit, +4 from exit.
    @(negedge clk);
    bus.ref_in[0] = 1'b1;
    push(0, 2);
    push(0, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.ref_in[0] = 1'b0;
      if (k == 2) bus.data_in[0] = 1'b1;
      if (k == 3) begin
        bus.ref_in[0]  = 1'b1;
        bus.data_in[0] = 1'b0;
      end
      if (k == 6) begin
        chk("pend hold up", int'(bus.up[0]), 1);
        chk("pend hold down", int'(bus.down[0]), 1);
      end
      if (k == 7) begin
        chk("pend exit up", int'(bus.up[0]), 1);
        chk("pend exit down", int'(bus.down[0]), 0);
      end
      if (k == 8) bus.data_in[0] = 1'b1;
    end
    drain(0);
    settle(0);

    for (int i = 0; i < 11; i++) apply(tbl[i]);

    // Async reset in the middle of UP_WAIT: immediate clear, no strobe.
    @(negedge clk);
    bus.ref_in[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid up before rst", int'(bus.up[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid up after rst", int'(bus.up[1]), 0);
    chk("mid phase_err ch0 after rst", err_of(0), 0);
    bus.ref_in[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid up after release", int'(bus.up[1]), 0);

`ifdef PFD_LOCK_DETECT_EN
    for (int i = 0; i < 16; i++) begin
      apply('{0, 1'b1, 0, 1'b1, 1, 1});
      chk($sformatf("lock0 after event %0d", i + 1), int'(bus.lock[0]), int'(i == 15));
      chk("lock1 idle", int'(bus.lock[1]), 0);
    end
    apply('{0, 1'b1, 0, 1'b1, 3, 3});
    chk("lock0 after +3", int'(bus.lock[0]), 0);
    chk("lock1 after +3", int'(bus.lock[1]), 0);
`else
    chk("lock tied low", int'(bus.lock), 0);
`endif

    chk("ch0 leftover expectations", q0.size(), 0);
    chk("ch1 leftover expectations", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
